// File: rtl/io_input_debounce.sv
// io_input_debounce: two-flop synchroniser plus per-bit debounce for the
// board slide switches (active-high) and push-buttons (active-low pins).
// Produces the zero-extended in_port0/in_port1 words for the input-port
// register stage and a one-cycle key_press pulse per debounced press.
//
// Optional build macro IO_DEBOUNCE_BYPASS_EN: removes the debounce counters
// so the stable level follows the second synchroniser flop directly
// (2-edge latency). This is meant for fast simulation only.
module io_input_debounce #(
  parameter int SW_WIDTH        = 10,
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic [31:0]          in_port0,
  output logic [31:0]          in_port1,
  output logic [KEY_WIDTH-1:0] key_press
);

  logic [SW_WIDTH-1:0]  sw_s1;
  logic [SW_WIDTH-1:0]  sw_s2;
  logic [KEY_WIDTH-1:0] key_s1;
  logic [KEY_WIDTH-1:0] key_s2;
  logic [KEY_WIDTH-1:0] key_lvl;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [KEY_WIDTH-1:0] key_stable;

  // Two-flop synchronisers; key pins idle high (released) out of reset.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Internally a key level of 1 means pressed.
  assign key_lvl = ~key_s2;

`ifdef IO_DEBOUNCE_BYPASS_EN

  assign sw_stable  = sw_s2;
  assign key_stable = key_lvl;

  // Pulse when the synchronised pressed level goes 0->1 on this edge.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      key_press <= '0;
    end else begin
      key_press <= ~key_s1 & key_s2;
    end
  end

`else

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] sw_cnt  [SW_WIDTH];
  logic [CNT_WIDTH-1:0] key_cnt [KEY_WIDTH];
  logic [SW_WIDTH-1:0]  sw_stable_q;
  logic [KEY_WIDTH-1:0] key_stable_q;

  assign sw_stable  = sw_stable_q;
  assign key_stable = key_stable_q;

  // Switch debounce: accept a new level only after it has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive edges; any return restarts.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sw_stable_q <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        sw_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sw_s2[i] == sw_stable_q[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_cnt[i] == CNT_MAX) begin
          sw_stable_q[i] <= sw_s2[i];
          sw_cnt[i]      <= '0;
        end else begin
          sw_cnt[i] <= sw_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Key debounce, same rule as switches, plus a pulse on each accepted press.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      key_stable_q <= '0;
      key_press    <= '0;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        key_cnt[i] <= '0;
      end
    end else begin
      key_press <= '0;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (key_lvl[i] == key_stable_q[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == CNT_MAX) begin
          key_stable_q[i] <= key_lvl[i];
          key_press[i]    <= key_lvl[i];
          key_cnt[i]      <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + CNT_ONE;
        end
      end
    end
  end

`endif

  assign in_port0 = 32'(sw_stable);
  assign in_port1 = 32'(key_stable);

endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed scenarios plus randomized traffic, checked
// against a sliding-window reference model of the debounced levels.
// Honours IO_DEBOUNCE_BYPASS_EN (model then follows the synchroniser only).
module tb_io_input_debounce;

  localparam int SW_W  = 10;
  localparam int KEY_W = 4;
  localparam int D     = 4;
`ifdef IO_DEBOUNCE_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = D + 2;
`endif

  logic             io_clk = 1'b0;
  logic             resetn = 1'b0;
  logic [SW_W-1:0]  sw     = '0;
  logic [KEY_W-1:0] key_n  = '1;
  logic [31:0]      in_port0;
  logic [31:0]      in_port1;
  logic [KEY_W-1:0] key_press;

  int n_cmp  = 0;
  int n_fail = 0;

  io_input_debounce #(
    .SW_WIDTH(SW_W), .KEY_WIDTH(KEY_W), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)
  ) dut (
    .io_clk(io_clk), .resetn(resetn), .sw(sw), .key_n(key_n),
    .in_port0(in_port0), .in_port1(in_port1), .key_press(key_press)
  );

  always #5 io_clk = ~io_clk;

  // Reference model: raw samples travel through a 2-deep queue; a bit's
  // stable level flips once the last D synchronised samples all disagree.
  logic [SW_W-1:0]  m_sw_sync[$];
  logic [KEY_W-1:0] m_key_sync[$];
`ifndef IO_DEBOUNCE_BYPASS_EN
  logic [SW_W-1:0]  m_sw_hist[$];
  logic [KEY_W-1:0] m_key_hist[$];
`endif
  logic [SW_W-1:0]  exp_sw    = '0;
  logic [KEY_W-1:0] exp_key   = '0;
  logic [KEY_W-1:0] exp_press = '0;

  function automatic void model_reset();
    m_sw_sync.delete();
    m_key_sync.delete();
    m_sw_sync.push_back('0);
    m_sw_sync.push_back('0);
    m_key_sync.push_back('1);
    m_key_sync.push_back('1);
`ifndef IO_DEBOUNCE_BYPASS_EN
    m_sw_hist.delete();
    m_key_hist.delete();
`endif
    exp_sw    = '0;
    exp_key   = '0;
    exp_press = '0;
  endfunction

  function automatic void model_edge(input logic [SW_W-1:0] raw_sw,
                                     input logic [KEY_W-1:0] raw_key_n);
    logic [SW_W-1:0]  s2_sw;
    logic [KEY_W-1:0] s2_pressed;
    logic [SW_W-1:0]  flip_sw;
    logic [KEY_W-1:0] flip_key;
    s2_sw      = m_sw_sync.pop_front();
    s2_pressed = ~m_key_sync.pop_front();
    m_sw_sync.push_back(raw_sw);
    m_key_sync.push_back(raw_key_n);
`ifdef IO_DEBOUNCE_BYPASS_EN
    flip_sw   = m_sw_sync[0];
    flip_key  = ~m_key_sync[0];
    exp_press = flip_key & ~exp_key;
    exp_sw    = flip_sw;
    exp_key   = flip_key;
    if (s2_sw != s2_sw) exp_sw = '0;
    if (s2_pressed != s2_pressed) exp_key = '0;
`else
    m_sw_hist.push_back(s2_sw);
    m_key_hist.push_back(s2_pressed);
    flip_sw  = '1;
    flip_key = '1;
    if (m_sw_hist.size() < D) begin
      flip_sw  = '0;
      flip_key = '0;
    end else begin
      for (int j = m_sw_hist.size() - D; j < m_sw_hist.size(); j++) begin
        flip_sw  &= m_sw_hist[j] ^ exp_sw;
        flip_key &= m_key_hist[j] ^ exp_key;
      end
    end
    exp_press = flip_key & ~exp_key;
    exp_sw   ^= flip_sw;
    exp_key  ^= flip_key;
    while (m_sw_hist.size() > D) m_sw_hist.delete(0);
    while (m_key_hist.size() > D) m_key_hist.delete(0);
`endif
  endfunction

  // One clock edge: advance the model, then settle to a sampling point.
  task automatic step();
    @(posedge io_clk);
    if (resetn) model_edge(sw, key_n);
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    sw     = 10'h3FF;
    key_n  = 4'h0;
    resetn = 1'b0;
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if ({in_port0, in_port1, key_press} !== {32'h0, 32'h0, 4'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_hold k=%0d: got p0=%h p1=%h kp=%h want 0/0/0",
                 k, in_port0, in_port1, key_press);
      end
    end
    resetn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++;
      if ({in_port0, in_port1, key_press} !==
          {(k >= LAT) ? 32'h3FF : 32'h0, (k >= LAT) ? 32'hF : 32'h0,
           (k == LAT) ? 4'hF : 4'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_release k=%0d: got p0=%h p1=%h kp=%h", k,
                 in_port0, in_port1, key_press);
      end
      n_cmp++;
      if ({in_port0, in_port1, key_press} !== {32'(exp_sw), 32'(exp_key), exp_press}) begin
        n_fail++;
        $display("[TB] FAIL reset_model k=%0d: got %h/%h/%h want %h/%h/%h", k,
                 in_port0, in_port1, key_press, exp_sw, exp_key, exp_press);
      end
    end
  endtask

`ifndef IO_DEBOUNCE_BYPASS_EN
  task automatic test_glitch();
    sw    = '0;
    key_n = '1;
    repeat (12) step();
    n_cmp++;
    if (in_port0 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL glitch_settle: got p0=%h want 0", in_port0);
    end
    sw[0] = 1'b1;
    repeat (3) step();
    sw[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++;
      if (in_port0[0] !== 1'b0 || in_port0 !== 32'(exp_sw)) begin
        n_fail++;
        $display("[TB] FAIL glitch k=%0d: got p0=%h want %h", k, in_port0, exp_sw);
      end
    end
  endtask

  task automatic test_bounce();
    sw    = '0;
    key_n = '1;
    repeat (12) step();
    for (int k = 0; k < 12; k++) begin
      sw[3] = ((k / 2) % 2 == 0);
      step();
      n_cmp++;
      if (in_port0[3] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bounce_early k=%0d: got bit3=%b want 0", k, in_port0[3]);
      end
    end
    sw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if (in_port0 !== ((k >= 6) ? 32'h8 : 32'h0)) begin
        n_fail++;
        $display("[TB] FAIL bounce_settle k=%0d: got p0=%h want %h", k, in_port0,
                 (k >= 6) ? 32'h8 : 32'h0);
      end
    end
  endtask
`endif

  task automatic test_press_release();
    sw    = '0;
    key_n = '1;
    repeat (12) step();
    key_n = 4'b1101;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if ({in_port1, key_press} !== {(k >= LAT) ? 32'h2 : 32'h0,
                                     (k == LAT) ? 4'b0010 : 4'b0000}) begin
        n_fail++;
        $display("[TB] FAIL press k=%0d: got p1=%h kp=%b", k, in_port1, key_press);
      end
    end
    key_n = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if ({in_port1, key_press} !== {(k >= LAT) ? 32'h0 : 32'h2, 4'b0000}) begin
        n_fail++;
        $display("[TB] FAIL release k=%0d: got p1=%h kp=%b", k, in_port1, key_press);
      end
    end
  endtask

  task automatic test_reset_mid();
    sw    = '0;
    key_n = '1;
    repeat (12) step();
    key_n = 4'hE;
    repeat (3) step();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({in_port0, in_port1, key_press} !== {32'h0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_async: got p0=%h p1=%h kp=%h want 0/0/0",
               in_port0, in_port1, key_press);
    end
    repeat (3) begin
      step();
      n_cmp++;
      if ({in_port1, key_press} !== {32'h0, 4'h0}) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_hold: got p1=%h kp=%h want 0/0", in_port1, key_press);
      end
    end
    resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if ({in_port1, key_press} !== {(k >= LAT) ? 32'h1 : 32'h0,
                                     (k == LAT) ? 4'h1 : 4'h0}) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_restart k=%0d: got p1=%h kp=%h", k,
                 in_port1, key_press);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        sw    = SW_W'($urandom);
        key_n = KEY_W'($urandom);
        hold  = $urandom_range(1, 9);
      end
      hold--;
      step();
      n_cmp++;
      if ({in_port0, in_port1, key_press} !== {32'(exp_sw), 32'(exp_key), exp_press}) begin
        n_fail++;
        $display("[TB] FAIL random k=%0d: got %h/%h/%h want %h/%h/%h", k,
                 in_port0, in_port1, key_press, exp_sw, exp_key, exp_press);
      end
    end
  endtask

`ifdef IO_DEBOUNCE_BYPASS_EN
  task automatic test_bypass();
    sw    = '0;
    key_n = '1;
    repeat (5) step();
    sw = 10'h155;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (in_port0 !== ((k >= 2) ? 32'h155 : 32'h0)) begin
        n_fail++;
        $display("[TB] FAIL bypass_level k=%0d: got p0=%h", k, in_port0);
      end
    end
    sw = 10'h154;
    step();
    sw = 10'h155;
    step();
    n_cmp++;
    if (in_port0 !== 32'h154) begin
      n_fail++;
      $display("[TB] FAIL bypass_glitch: got p0=%h want 154", in_port0);
    end
    step();
    n_cmp++;
    if (in_port0 !== 32'h155) begin
      n_fail++;
      $display("[TB] FAIL bypass_recover: got p0=%h want 155", in_port0);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef IO_DEBOUNCE_BYPASS_EN
    test_glitch();
`endif
    test_press_release();
`ifndef IO_DEBOUNCE_BYPASS_EN
    test_bounce();
`endif
    test_reset_mid();
    test_random();
`ifdef IO_DEBOUNCE_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
